// File: rtl/face_dispatch.sv
// Instruction front-end for the systolic multiply engine: queues
// instructions, applies address-sets and issues one calculation at a time.
module face_dispatch #(
  parameter int          ADDR_W       = 32,
  parameter int          BASE_W       = 19,
  parameter int          SIZE_W       = 11,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          STATE_W      = 4,
  parameter logic [6:0]  SYS_OPCODE   = 7'b0001011,
  parameter logic [2:0]  FUNC_ADDRSET = 3'd0,
  parameter logic [2:0]  FUNC_CALC    = 3'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  input  logic [STATE_W-1:0] engine_state,
  output logic               calc_init,
  output logic [1:0]         ctrl_mode,
  output logic [2:0]         mem_mode,
  output logic [SIZE_W-1:0]  matrix_size,
  output logic [ADDR_W-1:0]  base_left,
  output logic [ADDR_W-1:0]  base_right,
  output logic [ADDR_W-1:0]  base_addsrc,
  output logic [ADDR_W-1:0]  base_save,
  output logic               busy,
  output logic               done,
  output logic               illegal_err,
  output logic [15:0]        calc_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [ADDR_W-1:0] left_q, left_d;
  logic [ADDR_W-1:0] right_q, right_d;
  logic [ADDR_W-1:0] addsrc_q, addsrc_d;
  logic [ADDR_W-1:0] save_q, save_d;
  logic [1:0]        mode_q, mode_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              illegal_q, illegal_d;
  logic              done_q, done_d;
  logic [15:0]       ccount_q, ccount_d;

  logic              push, pop;
  logic [31:0]       head;
  logic [6:0]        h_op;
  logic [2:0]        h_func;
  logic [1:0]        h_sel;
  logic [ADDR_W-1:0] h_base;
  logic              unused_head;

  assign instr_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push        = instr_valid && instr_ready;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);

  assign head        = mem_q[rd_ptr_q];
  assign h_op        = head[6:0];
  assign h_func      = head[9:7];
  assign h_sel       = head[11:10];
  assign h_base      = ADDR_W'(head[12+BASE_W-1:12]);
  assign unused_head = head[31];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instr;
  end

  // Head is only decoded while idle, so bases and mode hold during a calc.
  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    right_d   = right_q;
    addsrc_d  = addsrc_q;
    save_d    = save_q;
    mode_d    = mode_q;
    size_d    = size_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    ccount_d  = ccount_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop && h_op == SYS_OPCODE) begin
          if (h_func == FUNC_ADDRSET) begin
            unique case (h_sel)
              2'b00:   left_d   = h_base;
              2'b01:   right_d  = h_base;
              2'b10:   addsrc_d = h_base;
              default: save_d   = h_base;
            endcase
          end else if (h_func == FUNC_CALC) begin
            mode_d  = h_sel;
            size_d  = head[12+SIZE_W-1:12];
            state_d = S_ISSUE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (engine_state != '0) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (engine_state == '0) begin
          done_d   = 1'b1;
          ccount_d = ccount_q + 16'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      addsrc_q  <= '0;
      save_q    <= '0;
      mode_q    <= '0;
      size_q    <= '0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      ccount_q  <= '0;
    end else begin
      state_q   <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_q + CNT_W'(push) - CNT_W'(pop);
      left_q    <= left_d;
      right_q   <= right_d;
      addsrc_q  <= addsrc_d;
      save_q    <= save_d;
      mode_q    <= mode_d;
      size_q    <= size_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
      ccount_q  <= ccount_d;
    end
  end

  assign calc_init   = (state_q == S_ISSUE);
  assign ctrl_mode   = mode_q;
  assign mem_mode    = (mode_q == 2'b11) ? 3'd2 : 3'd1;
  assign matrix_size = size_q;
  assign base_left   = left_q;
  assign base_right  = right_q;
  assign base_addsrc = addsrc_q;
  assign base_save   = save_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign done        = done_q;
  assign illegal_err = illegal_q;
  assign calc_count  = ccount_q;

endmodule

// File: tb/tb_face_dispatch.sv
// Directed bench for face_dispatch: address-sets, calc issue timing,
// FIFO back-pressure, illegal funcs, back-to-back calcs, mid-calc reset.
module tb_face_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [3:0]  engine_state;
  logic        calc_init;
  logic [1:0]  ctrl_mode;
  logic [2:0]  mem_mode;
  logic [10:0] matrix_size;
  logic [31:0] base_left, base_right, base_addsrc, base_save;
  logic        busy, done, illegal_err;
  logic [15:0] calc_count;

  int n_cmp = 0;
  int n_err = 0;
  int init_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  face_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .engine_state(engine_state), .calc_init(calc_init),
    .ctrl_mode(ctrl_mode), .mem_mode(mem_mode), .matrix_size(matrix_size),
    .base_left(base_left), .base_right(base_right),
    .base_addsrc(base_addsrc), .base_save(base_save),
    .busy(busy), .done(done), .illegal_err(illegal_err),
    .calc_count(calc_count)
  );

  always @(negedge clk) begin
    if (calc_init === 1'b1) init_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    instr_valid = 1'b1;
    instr = v;
    tick();
    instr_valid = 1'b0;
    instr = '0;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f,
                                     input logic [1:0] s,
                                     input logic [18:0] p);
    return {1'b0, p, s, f, 7'b0001011};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    engine_state = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0h want 1", instr_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0h want 0", busy); end
    n_cmp++; if (calc_count !== 16'd0) begin n_err++; $display("FAIL rst_count got %0h want 0", calc_count); end
    n_cmp++; if (illegal_err !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %0h want 0", illegal_err); end
    n_cmp++; if (mem_mode !== 3'd1) begin n_err++; $display("FAIL rst_mem_mode got %0h want 1", mem_mode); end
    n_cmp++; if ({calc_init, done} !== 2'b00) begin n_err++; $display("FAIL rst_pulses got %b want 00", {calc_init, done}); end
    n_cmp++; if (base_left !== 32'd0) begin n_err++; $display("FAIL rst_base_left got %h want 0", base_left); end
  endtask

  task automatic test_addrset;
    push(mk(3'd0, 2'b01, 19'h1234));
    push(mk(3'd0, 2'b00, 19'h00777));
    n_cmp++; if (base_right !== 32'h00001234) begin n_err++; $display("FAIL as_right got %h want 00001234", base_right); end
    tick();
    n_cmp++; if (base_left !== 32'h00000777) begin n_err++; $display("FAIL as_left got %h want 00000777", base_left); end
    n_cmp++; if ({base_addsrc, base_save} !== 64'd0) begin n_err++; $display("FAIL as_others got %h want 0", {base_addsrc, base_save}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL as_busy got %0h want 0", busy); end
  endtask

  task automatic test_calc;
    int i0, d0;
    i0 = init_cnt;
    d0 = done_cnt;
    push(mk(3'd1, 2'b11, 19'd64));
    n_cmp++; if (calc_init !== 1'b0) begin n_err++; $display("FAIL calc_early_init got %0h want 0", calc_init); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL calc_busy got %0h want 1", busy); end
    tick();
    n_cmp++; if (calc_init !== 1'b1) begin n_err++; $display("FAIL calc_init got %0h want 1", calc_init); end
    n_cmp++; if (mem_mode !== 3'd2) begin n_err++; $display("FAIL calc_mem_mode got %0h want 2", mem_mode); end
    n_cmp++; if (matrix_size !== 11'd64) begin n_err++; $display("FAIL calc_size got %0d want 64", matrix_size); end
    n_cmp++; if (ctrl_mode !== 2'b11) begin n_err++; $display("FAIL calc_mode got %0h want 3", ctrl_mode); end
    tick();
    tick();
    engine_state = 4'd3;
    repeat (10) tick();
    n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL calc_early_done got %0d want %0d", done_cnt, d0); end
    engine_state = 4'd0;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL calc_done got %0h want 1", done); end
    n_cmp++; if (calc_count !== 16'd1) begin n_err++; $display("FAIL calc_count got %0d want 1", calc_count); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL calc_done_len got %0h want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL calc_idle got %0h want 0", busy); end
    n_cmp++; if (init_cnt - i0 !== 1) begin n_err++; $display("FAIL calc_init_pulses got %0d want 1", init_cnt - i0); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL calc_done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_full;
    int i0;
    i0 = init_cnt;
    push(mk(3'd1, 2'b00, 19'd8));
    push(mk(3'd0, 2'b00, 19'd5));
    repeat (3) push(32'h00000013);
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0h want 0", instr_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy got %0h want 1", busy); end
    instr_valid = 1'b1;
    instr = mk(3'd1, 2'b11, 19'd1);
    tick();
    instr_valid = 1'b0;
    instr = '0;
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL full_hold got %0h want 0", instr_ready); end
    engine_state = 4'd3;
    repeat (3) tick();
    n_cmp++; if (base_left !== 32'h00000777) begin n_err++; $display("FAIL full_left_run got %h want 00000777", base_left); end
    engine_state = 4'd0;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done got %0h want 1", done); end
    n_cmp++; if (base_left !== 32'h00000777) begin n_err++; $display("FAIL full_left_done got %h want 00000777", base_left); end
    tick();
    n_cmp++; if (base_left !== 32'd5) begin n_err++; $display("FAIL full_left_after got %h want 00000005", base_left); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after got %0h want 1", instr_ready); end
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_drain got %0h want 0", busy); end
    n_cmp++; if (init_cnt - i0 !== 1) begin n_err++; $display("FAIL full_init_pulses got %0d want 1", init_cnt - i0); end
    n_cmp++; if (calc_count !== 16'd2) begin n_err++; $display("FAIL full_count got %0d want 2", calc_count); end
  endtask

  task automatic test_illegal;
    int i0;
    i0 = init_cnt;
    n_cmp++; if (illegal_err !== 1'b0) begin n_err++; $display("FAIL ill_pre got %0h want 0", illegal_err); end
    push(mk(3'd5, 2'b00, 19'd0));
    push(32'h00000033);
    tick();
    n_cmp++; if (illegal_err !== 1'b1) begin n_err++; $display("FAIL ill_set got %0h want 1", illegal_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ill_consumed got %0h want 0", busy); end
    repeat (3) tick();
    n_cmp++; if (illegal_err !== 1'b1) begin n_err++; $display("FAIL ill_sticky got %0h want 1", illegal_err); end
    n_cmp++; if (init_cnt !== i0) begin n_err++; $display("FAIL ill_init got %0d want %0d", init_cnt, i0); end
  endtask

  task automatic test_back_to_back;
    int i0, d0, t;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (illegal_err !== 1'b0) begin n_err++; $display("FAIL b2b_ill_clr got %0h want 0", illegal_err); end
    i0 = init_cnt;
    d0 = done_cnt;
    push(mk(3'd1, 2'b00, 19'd16));
    push(mk(3'd1, 2'b11, 19'd32));
    t = 0;
    while (calc_init !== 1'b1 && t < 20) begin tick(); t++; end
    n_cmp++; if (t >= 20) begin n_err++; $display("FAIL b2b_wait1 got timeout want calc_init"); end
    n_cmp++; if (mem_mode !== 3'd1) begin n_err++; $display("FAIL b2b_mem1 got %0h want 1", mem_mode); end
    n_cmp++; if (matrix_size !== 11'd16) begin n_err++; $display("FAIL b2b_size1 got %0d want 16", matrix_size); end
    tick();
    tick();
    engine_state = 4'd3;
    repeat (4) tick();
    engine_state = 4'd0;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done1 got %0h want 1", done); end
    n_cmp++; if (calc_count !== 16'd1) begin n_err++; $display("FAIL b2b_count1 got %0d want 1", calc_count); end
    tick();
    n_cmp++; if (calc_init !== 1'b1) begin n_err++; $display("FAIL b2b_init2 got %0h want 1", calc_init); end
    n_cmp++; if (mem_mode !== 3'd2) begin n_err++; $display("FAIL b2b_mem2 got %0h want 2", mem_mode); end
    n_cmp++; if (matrix_size !== 11'd32) begin n_err++; $display("FAIL b2b_size2 got %0d want 32", matrix_size); end
    tick();
    tick();
    engine_state = 4'd3;
    repeat (4) tick();
    engine_state = 4'd0;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done2 got %0h want 1", done); end
    tick();
    n_cmp++; if (calc_count !== 16'd2) begin n_err++; $display("FAIL b2b_count2 got %0d want 2", calc_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %0h want 0", busy); end
    n_cmp++; if (init_cnt - i0 !== 2) begin n_err++; $display("FAIL b2b_inits got %0d want 2", init_cnt - i0); end
    n_cmp++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL b2b_dones got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int d0, t;
    push(mk(3'd0, 2'b11, 19'd9));
    push(mk(3'd1, 2'b01, 19'd4));
    t = 0;
    while (calc_init !== 1'b1 && t < 20) begin tick(); t++; end
    n_cmp++; if (t >= 20) begin n_err++; $display("FAIL mid_wait got timeout want calc_init"); end
    tick();
    engine_state = 4'd3;
    tick();
    push(32'h00000013);
    n_cmp++; if (base_save !== 32'd9) begin n_err++; $display("FAIL mid_save_pre got %h want 00000009", base_save); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre got %0h want 1", busy); end
    d0 = done_cnt;
    rst_n = 1'b0;
    engine_state = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL mid_done got %0d want %0d", done_cnt, d0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %0h want 0", busy); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %0h want 1", instr_ready); end
    n_cmp++; if (calc_count !== 16'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", calc_count); end
    n_cmp++; if ({base_left, base_right, base_addsrc, base_save} !== 128'd0) begin n_err++; $display("FAIL mid_bases got %h want 0", {base_left, base_right, base_addsrc, base_save}); end
    n_cmp++; if (mem_mode !== 3'd1) begin n_err++; $display("FAIL mid_mem_mode got %0h want 1", mem_mode); end
  endtask

  initial begin
    test_reset();
    test_addrset();
    test_calc();
    test_full();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
